// File: rtl/dmem_ctrl.sv
// Data-memory controller: word SRAM behind the memory-stage request/byte-enable port,
// with fixed wait states. Optional range trap enabled by defining DMEM_FAULT_EN.
package pkg_opengpu;
  parameter int DATA_WIDTH = 32;
  parameter int ADDR_WIDTH = 32;
endpackage

module dmem_ctrl
  import pkg_opengpu::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_we,
  input  logic [ADDR_WIDTH-1:0] i_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_dmem_wdata,
  input  logic [3:0]            i_dmem_be,
  output logic [DATA_WIDTH-1:0] o_dmem_rdata,
  output logic                  o_dmem_valid,
  output logic                  o_ctrl_busy,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  input  logic                  i_err_clear
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;

  logic                  w_capture;
  logic                  w_commit;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic [3:0]            w_acc_be;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_unused;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_dmem_req) w_state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt <= 4'd1) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= i_dmem_we;
        r_addr  <= i_dmem_addr;
        r_wdata <= i_dmem_wdata;
        r_be    <= i_dmem_be;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign w_capture    = (r_state == ST_IDLE) && i_dmem_req;
  assign w_commit     = (w_state_next == ST_RESP) && (r_state != ST_RESP);
  assign o_dmem_valid = (r_state == ST_RESP);
  assign o_ctrl_busy  = (r_state != ST_IDLE);

  // With zero wait states the array is accessed on the capture edge itself,
  // so the live request payload has to bypass the request registers.
  assign w_acc_we    = (r_state == ST_IDLE) ? i_dmem_we    : r_we;
  assign w_acc_addr  = (r_state == ST_IDLE) ? i_dmem_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? i_dmem_wdata : r_wdata;
  assign w_acc_be    = (r_state == ST_IDLE) ? i_dmem_be    : r_be;

  assign w_off = w_acc_addr - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_rd;

    // Reset wins over a store committing on the same edge.
    always_ff @(posedge i_clk) begin
      if (w_commit && !i_rst && w_acc_we && w_acc_be[gi] && w_in_range)
        r_mem[w_idx] <= w_acc_wdata[gi*8 +: 8];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst)
        r_rd <= 8'd0;
      else if (w_commit && !w_acc_we)
        r_rd <= w_in_range ? r_mem[w_idx] : 8'd0;
    end

    assign o_dmem_rdata[gi*8 +: 8] = r_rd;
  end

`ifdef DMEM_FAULT_EN
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  assign w_in_range = (w_acc_addr >= BASE_ADDR) && (w_off[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign w_unused   = ^w_off[1:0];

  // A new fault beats a simultaneous clear and records its own address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_commit && !w_in_range) begin
      r_err <= 1'b1;
      if (!r_err || i_err_clear) r_err_addr <= w_acc_addr;
    end else if (i_err_clear) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end
  end

  assign o_err      = r_err;
  assign o_err_addr = r_err_addr;
`else
  assign w_in_range = 1'b1;
  assign w_unused   = ^{i_err_clear, w_off[1:0], w_off[ADDR_WIDTH-1:IDX_W+2]};
  assign o_err      = 1'b0;
  assign o_err_addr = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances with 1, 0 and 3 wait states
// (the last one with a non-zero base address), one task per scenario.
module tb_dmem_ctrl;

  localparam int WS [3] = '{1, 0, 3};
  localparam logic [31:0] BASE2 = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        clr   [3];
  logic [31:0] rdata [3];
  logic        valid [3];
  logic        busy  [3];
  logic        err   [3];
  logic [31:0] eaddr [3];

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_dmem_req(req[0]), .i_dmem_we(we[0]),
    .i_dmem_addr(addr[0]), .i_dmem_wdata(wdata[0]), .i_dmem_be(be[0]),
    .o_dmem_rdata(rdata[0]), .o_dmem_valid(valid[0]), .o_ctrl_busy(busy[0]),
    .o_err(err[0]), .o_err_addr(eaddr[0]), .i_err_clear(clr[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_dmem_req(req[1]), .i_dmem_we(we[1]),
    .i_dmem_addr(addr[1]), .i_dmem_wdata(wdata[1]), .i_dmem_be(be[1]),
    .o_dmem_rdata(rdata[1]), .o_dmem_valid(valid[1]), .o_ctrl_busy(busy[1]),
    .o_err(err[1]), .o_err_addr(eaddr[1]), .i_err_clear(clr[1])
  );

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(BASE2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_dmem_req(req[2]), .i_dmem_we(we[2]),
    .i_dmem_addr(addr[2]), .i_dmem_wdata(wdata[2]), .i_dmem_be(be[2]),
    .o_dmem_rdata(rdata[2]), .o_dmem_valid(valid[2]), .o_ctrl_busy(busy[2]),
    .o_err(err[2]), .o_err_addr(eaddr[2]), .i_err_clear(clr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access on instance d; returns cycles from request to valid (99 on timeout).
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] b,
                        output int lat, output logic [31:0] rd);
    bit done;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat; be[d] = b;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (valid[d]) done = 1'b1;
    end
    rd = rdata[d];
    req[d] = 1'b0;
    if (!done) lat = 99;
    $display("xact dut%0d %s addr=%08h wdata=%08h be=%b lat=%0d rdata=%08h",
             d, w ? "ST" : "LD", a, dat, b, lat, rd);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (valid[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== 32'h0 ||
          err[d] !== 1'b0 || eaddr[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d: valid=%b busy=%b rdata=%08h err=%b eaddr=%08h, want all zero",
                 d, valid[d], busy[d], rdata[d], err[d], eaddr[d]);
      end
    end
    rst = 1'b0;
    $display("xact reset released");
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd;
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL st_latency got=%0d want=2", lat); end
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL ld_latency got=%0d want=2", lat); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_data got=%08h want=deadbeef", rd); end
    // a store response must leave the previous read word on the bus
    access(0, 1'b1, 32'h14, 32'h7777_7777, 4'hF, lat, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_keeps_rdata got=%08h want=deadbeef", rd); end
  endtask

  task automatic test_byte_enable;
    int lat; logic [31:0] rd;
    access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, rd);
    access(0, 1'b1, 32'h20, 32'hAAAA_AAAA, 4'b0100, lat, rd);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd);
    total++;
    if (rd !== 32'h11AA_3344) begin bad++; $display("FAIL be_lane2 got=%08h want=11aa3344", rd); end
    access(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, lat, rd);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL be_zero_latency got=%0d want=2", lat); end
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h11AA_3344) begin bad++; $display("FAIL be_zero got=%08h want=11aa3344", rd); end
  endtask

  task automatic test_payload_hold;
    int lat; logic [31:0] rd;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'h0; be[0] = 4'h0;
    @(posedge clk); #1;
    total++;
    if (busy[0] !== 1'b1 || valid[0] !== 1'b0) begin
      bad++; $display("FAIL hold_wait busy=%b valid=%b want busy=1 valid=0", busy[0], valid[0]);
    end
    we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h0; be[0] = 4'hF;
    @(posedge clk); #1;
    total++;
    if (valid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL hold_payload valid=%b rdata=%08h want valid=1 rdata=deadbeef", valid[0], rdata[0]);
    end
    req[0] = 1'b0;
    $display("xact dut0 LD addr=00000010 with payload switched after capture rdata=%08h", rdata[0]);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h11AA_3344) begin bad++; $display("FAIL hold_no_store got=%08h want=11aa3344", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; int cyc; int pulses;
    logic [31:0] rd;
    logic [31:0] exp_d [3];
    logic [31:0] adr_d [3];
    exp_d = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};
    adr_d = '{32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 3; i++) access(1, 1'b1, adr_d[i], exp_d[i], 4'hF, lat, rd);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL ws0_latency got=%0d want=1", lat); end
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = adr_d[0]; be[1] = 4'h0;
    cyc = 0; pulses = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (valid[1]) begin
        pulses++;
        $display("xact dut1 LD back-to-back pulse=%0d cycle=%0d rdata=%08h", pulses, cyc, rdata[1]);
        if (pulses <= 3) begin
          total++;
          if (cyc !== 2*pulses-1 || rdata[1] !== exp_d[pulses-1]) begin
            bad++;
            $display("FAIL b2b_pulse%0d cycle=%0d rdata=%08h want cycle=%0d rdata=%08h",
                     pulses, cyc, rdata[1], 2*pulses-1, exp_d[pulses-1]);
          end
        end
        if (pulses < 3) addr[1] = adr_d[pulses];
        else req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    total++;
    if (pulses !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", pulses); end
  endtask

  // Reset sampled k edges after the capture edge; k=3 coincides with the commit edge.
  task automatic test_reset_mid(input int k, input logic [31:0] dat);
    int lat; int seen;
    logic [31:0] rd;
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE2 + 32'h40; wdata[2] = dat; be[2] = 4'hF;
    @(posedge clk);
    repeat (k-1) @(posedge clk);
    #1;
    total++;
    if (busy[2] !== 1'b1) begin bad++; $display("FAIL rstmid%0d_busy got=%b want=1", k, busy[2]); end
    rst = 1'b1; req[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
      bad++; $display("FAIL rstmid%0d_idle valid=%b busy=%b want 0 0", k, valid[2], busy[2]);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (valid[2]) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rstmid%0d_novalid pulses=%0d want=0", k, seen); end
    access(2, 1'b0, BASE2 + 32'h40, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL rstmid%0d_dropped got=%08h want=0badf00d", k, rd); end
  endtask

  task automatic test_ws3_base;
    int lat; logic [31:0] rd;
    access(2, 1'b1, BASE2 + 32'h40, 32'h0BAD_F00D, 4'hF, lat, rd);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL ws3_latency got=%0d want=4", lat); end
    test_reset_mid(1, 32'hFFFF_FFFF);
    test_reset_mid(3, 32'h1234_5678);
  endtask

`ifdef DMEM_FAULT_EN
  task automatic test_fault;
    int lat; logic [31:0] rd;
    access(0, 1'b1, 32'h0, 32'h0102_0304, 4'hF, lat, rd);
    access(0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd);
    total++;
    if (lat !== 2 || rd !== 32'h0) begin bad++; $display("FAIL fault_ld lat=%0d rdata=%08h want lat=2 rdata=0", lat, rd); end
    total++;
    if (err[0] !== 1'b1 || eaddr[0] !== 32'h1000) begin
      bad++; $display("FAIL fault_flag err=%b eaddr=%08h want 1 00001000", err[0], eaddr[0]);
    end
    access(0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, lat, rd);
    total++;
    if (lat !== 2 || err[0] !== 1'b1 || eaddr[0] !== 32'h1000) begin
      bad++; $display("FAIL fault_first lat=%0d err=%b eaddr=%08h want 2 1 00001000", lat, err[0], eaddr[0]);
    end
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h0102_0304) begin bad++; $display("FAIL fault_no_store got=%08h want=01020304", rd); end
    @(posedge clk); #1; clr[0] = 1'b1;
    @(posedge clk); #1; clr[0] = 1'b0;
    total++;
    if (err[0] !== 1'b0 || eaddr[0] !== 32'h0) begin
      bad++; $display("FAIL fault_clear err=%b eaddr=%08h want 0 0", err[0], eaddr[0]);
    end
    clr[0] = 1'b1;
    access(0, 1'b0, 32'h3000, 32'h0, 4'h0, lat, rd);
    clr[0] = 1'b0;
    total++;
    if (err[0] !== 1'b1 || eaddr[0] !== 32'h3000) begin
      bad++; $display("FAIL fault_vs_clear err=%b eaddr=%08h want 1 00003000", err[0], eaddr[0]);
    end
    access(2, 1'b0, BASE2 - 32'h4, 32'h0, 4'h0, lat, rd);
    total++;
    if (err[2] !== 1'b1 || eaddr[2] !== BASE2 - 32'h4 || rd !== 32'h0) begin
      bad++; $display("FAIL fault_below_base err=%b eaddr=%08h rdata=%08h want 1 00000ffc 0", err[2], eaddr[2], rd);
    end
  endtask
`else
  task automatic test_wrap;
    int lat; logic [31:0] rd;
    clr[0] = 1'b1;
    access(0, 1'b1, 32'h1004, 32'h0000_0005, 4'hF, lat, rd);
    clr[0] = 1'b0;
    access(0, 1'b0, 32'h0004, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h5) begin bad++; $display("FAIL wrap_data got=%08h want=00000005", rd); end
    total++;
    if (err[0] !== 1'b0 || eaddr[0] !== 32'h0) begin
      bad++; $display("FAIL wrap_noerr err=%b eaddr=%08h want 0 0", err[0], eaddr[0]);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0; clr[d] = 1'b0;
    end
    test_reset;
    test_store_load;
    test_byte_enable;
    test_payload_hold;
    test_back_to_back;
    test_ws3_base;
`ifdef DMEM_FAULT_EN
    test_fault;
`else
    test_wrap;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
